fir_mac_scheduler: RTL and testbench
====================================

// Module: fir_mac_scheduler
// PURPOSE
//  Time-shares one multiply-accumulate (MAC) unit among the FIR stages of the PDM
//  decimation chain (98.3 MHz clk_m domain).
//  Each stage pulses a request when its decimator has a new input sample. The scheduler
//  arbitrates round-robin and sequences the shared MAC: clear, then TAPS accumulate
//  cycles. It then reports completion to the served stage.
// PARAMETERS
//  NUM_STAGES  4   number of FIR stages sharing the MAC (>=2)
//  TAPS        16  coefficients per FIR stage (>=2); one MAC cycle per tap
// PORTS
//  clk_in         in   1                      system clock (clk_m)
//  rst_in         in   1                      synchronous active-high reset
//  req_in         in   NUM_STAGES             1-cycle pulse per stage: new sample ready
//  mac_clear_out  out  1                      zero MAC accumulator this cycle
//  mac_en_out     out  1                      MAC accumulates tap tap_idx_out this cycle
//  mac_last_out   out  1                      high with mac_en_out on final tap
//  tap_idx_out    out  $clog2(TAPS)           coefficient/delay-line address
//  stage_sel_out  out  $clog2(NUM_STAGES)     stage currently owning the MAC
//  done_out       out  1                      1-cycle pulse: accumulator result valid
//  done_stage_out out  $clog2(NUM_STAGES)     stage index qualified by done_out
//  busy_out       out  1                      high in any state except IDLE
//  overrun_out    out  NUM_STAGES             sticky: request lost for that stage
// BEHAVIOUR
//  Reset:
//   - On reset, all outputs are 0, pending is 0, and the RR pointer is 0.
//   - The FSM goes to IDLE.
//   - Reset mid-job aborts the job: no done_out is issued and pending requests are discarded.
//  Pending register:
//   - pending[i] is set the cycle after req_in[i].
//   - pending[i] is cleared when stage i is selected (IDLE->CLEAR).
//   - If req_in[i] arrives in that same cycle, pending[i] stays set and no overrun is flagged.
//   - If req_in[i] arrives while pending[i]=1 and i is not being selected, overrun_out[i]
//     sets and the request is dropped. overrun_out clears only on reset.
//  FSM:
//   - IDLE: if pending != 0, select the first set bit searching from rr_ptr upward with wrap.
//     Latch the winner into stage_sel_out and go to CLEAR. Otherwise stay in IDLE.
//   - CLEAR: 1 cycle. mac_clear_out=1, mac_en_out=0, tap_idx_out=0. Go to RUN.
//   - RUN: TAPS cycles. mac_en_out=1 and tap_idx_out counts 0..TAPS-1.
//     mac_last_out=1 when tap_idx_out==TAPS-1, then go to DONE.
//   - DONE: 1 cycle. done_out=1 and done_stage_out=stage_sel_out.
//     rr_ptr <= (stage_sel_out+1) mod NUM_STAGES. Go to IDLE.
//  Outputs and timing:
//   - All outputs are registered from state. stage_sel_out holds its value from CLEAR through DONE.
//   - Latency: req at cycle t -> CLEAR at t+2 -> first RUN at t+3 -> done_out at t+3+TAPS.
//   - Occupancy is TAPS+3 cycles per job, counting the IDLE cycle.
//  Arbitration and capacity:
//   - Requests arriving during a job wait in pending.
//   - Simultaneous requests are served in round-robin order; no stage is starved.
//   - Stage 0 is fed every 32 clk_m (3.072 MHz), so the default sizing keeps total load below 1.
//  Invariants:
//   - mac_clear_out and mac_en_out are never high together.
//   - done_out fires exactly once per granted job.
// TESTING
//  1. Reset, then req_in=4'b0001 at cycle 10:
//     -> mac_clear_out@12; mac_en_out@13..28 with tap_idx 0..15; mac_last_out@28;
//        done_out@29 with done_stage=0.
//  2. req_in=4'b1111 in one cycle:
//     -> done_out order: stages 0,1,2,3; 19-cycle spacing; no overrun.
//  3. After serving stage 2, req_in=4'b0101 together:
//     -> stage 0 is served first (rr_ptr=3 wraps to 0), then stage 2.
//  4. Two req_in[1] pulses while stage 0 is busy:
//     -> overrun_out=4'b0010 (sticky); stage 1 is served exactly once.
//  5. req_in[3] in the same cycle as IDLE->CLEAR for stage 3:
//     -> no overrun; stage 3 is served twice back-to-back.
//  6. rst_in asserted at RUN tap 7:
//     -> next cycle all outputs are 0 and busy_out=0; no done_out; pending and overrun are cleared.

Source files
------------

// File: rtl/fir_mac_scheduler.sv
// fir_mac_scheduler
//   Shares one multiply-accumulate unit between the FIR stages of the PDM
//   decimation chain. Stages pulse a request when a new input sample is
//   ready. The scheduler latches each request into a pending bit. It then
//   grants the MAC round-robin and runs a fixed job for the granted stage:
//   one clear cycle, TAPS accumulate cycles and one done cycle.
//
// Ports
//   clk_in         system clock (clk_m)
//   rst_in         synchronous active-high reset; aborts any job in flight
//   req_in         per-stage 1-cycle request pulse (new sample ready)
//   mac_clear_out  zero the MAC accumulator this cycle
//   mac_en_out     MAC accumulates tap tap_idx_out this cycle
//   mac_last_out   final tap of the job (qualifies mac_en_out)
//   tap_idx_out    coefficient / delay-line address
//   stage_sel_out  stage owning the MAC; held from CLEAR through DONE
//   done_out       1-cycle pulse: accumulator result is valid
//   done_stage_out stage the done_out pulse belongs to
//   busy_out       high whenever the FSM is not idle
//   overrun_out    sticky per-stage flag: a request was lost
module fir_mac_scheduler #(
   parameter int NUM_STAGES = 4,
   parameter int TAPS       = 16,
   localparam int SW        = $clog2(NUM_STAGES),
   localparam int TW        = $clog2(TAPS)
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic [NUM_STAGES-1:0] req_in,
   output logic                  mac_clear_out,
   output logic                  mac_en_out,
   output logic                  mac_last_out,
   output logic [TW-1:0]         tap_idx_out,
   output logic [SW-1:0]         stage_sel_out,
   output logic                  done_out,
   output logic [SW-1:0]         done_stage_out,
   output logic                  busy_out,
   output logic [NUM_STAGES-1:0] overrun_out
);

   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DONE} state_t;

   localparam logic [TW-1:0] TAP_LAST = TW'(TAPS - 1);
   localparam logic [SW-1:0] STG_LAST = SW'(NUM_STAGES - 1);

   state_t                  state, state_nxt;
   logic [NUM_STAGES-1:0]   pending;
   logic [SW-1:0]           rr_ptr, rr_nxt;

   logic                    found;
   logic [SW-1:0]           win, cand;
   logic                    grant;
   logic [NUM_STAGES-1:0]   sel_vec;

   logic                    clear_nxt, en_nxt, last_nxt, done_nxt, busy_nxt;
   logic [TW-1:0]           tap_nxt;
   logic [SW-1:0]           sel_nxt, done_stage_nxt;

   // Round-robin search: first pending stage at or above rr_ptr, with wrap.
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
         cand = SW'((int'(rr_ptr) + k) % NUM_STAGES);
         if (!found && pending[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   assign grant = (state == S_IDLE) && found;

   // One-hot of the stage being granted this cycle. Its pending bit is
   // consumed, so a coincident new request for it is kept, not flagged.
   always_comb begin
      sel_vec = '0;
      for (int i = 0; i < NUM_STAGES; i++)
         sel_vec[i] = grant && (win == SW'(i));
   end

   // Next state and next-cycle outputs; all outputs are registered below.
   always_comb begin
      state_nxt      = state;
      clear_nxt      = 1'b0;
      en_nxt         = 1'b0;
      last_nxt       = 1'b0;
      tap_nxt        = '0;
      done_nxt       = 1'b0;
      done_stage_nxt = '0;
      sel_nxt        = stage_sel_out;
      rr_nxt         = rr_ptr;
      case (state)
         S_IDLE: begin
            if (grant) begin
               state_nxt = S_CLEAR;
               sel_nxt   = win;
               clear_nxt = 1'b1;
            end
         end
         S_CLEAR: begin
            state_nxt = S_RUN;
            en_nxt    = 1'b1;
         end
         S_RUN: begin
            if (tap_idx_out == TAP_LAST) begin
               state_nxt      = S_DONE;
               done_nxt       = 1'b1;
               done_stage_nxt = stage_sel_out;
            end else begin
               en_nxt   = 1'b1;
               tap_nxt  = tap_idx_out + 1'b1;
               last_nxt = (tap_nxt == TAP_LAST);
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
            rr_nxt    = (stage_sel_out == STG_LAST) ? '0 : stage_sel_out + 1'b1;
         end
         default: state_nxt = S_IDLE;
      endcase
      busy_nxt = (state_nxt != S_IDLE);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state          <= S_IDLE;
         pending        <= '0;
         rr_ptr         <= '0;
         mac_clear_out  <= 1'b0;
         mac_en_out     <= 1'b0;
         mac_last_out   <= 1'b0;
         tap_idx_out    <= '0;
         stage_sel_out  <= '0;
         done_out       <= 1'b0;
         done_stage_out <= '0;
         busy_out       <= 1'b0;
         overrun_out    <= '0;
      end else begin
         state          <= state_nxt;
         pending        <= req_in | (pending & ~sel_vec);
         overrun_out    <= overrun_out | (req_in & pending & ~sel_vec);
         rr_ptr         <= rr_nxt;
         mac_clear_out  <= clear_nxt;
         mac_en_out     <= en_nxt;
         mac_last_out   <= last_nxt;
         tap_idx_out    <= tap_nxt;
         stage_sel_out  <= sel_nxt;
         done_out       <= done_nxt;
         done_stage_out <= done_stage_nxt;
         busy_out       <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Bench for fir_mac_scheduler. A job-timeline reference model (pending bits,
// round-robin pointer, and the age of the running job) predicts every output
// after each clock edge. Directed scenarios add explicit latency/order checks.
module tb_fir_mac_scheduler;
   localparam int N = 4;
   localparam int T = 16;

   logic         clk_in = 1'b0;
   logic         rst_in;
   logic [N-1:0] req_in;
   logic         mac_clear_out, mac_en_out, mac_last_out, done_out, busy_out;
   logic [3:0]   tap_idx_out;
   logic [1:0]   stage_sel_out, done_stage_out;
   logic [N-1:0] overrun_out;

   fir_mac_scheduler #(.NUM_STAGES(N), .TAPS(T)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .req_in(req_in),
      .mac_clear_out(mac_clear_out), .mac_en_out(mac_en_out),
      .mac_last_out(mac_last_out), .tap_idx_out(tap_idx_out),
      .stage_sel_out(stage_sel_out), .done_out(done_out),
      .done_stage_out(done_stage_out), .busy_out(busy_out),
      .overrun_out(overrun_out));

   always #5 clk_in = ~clk_in;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: a job is described only by its age since the grant edge.
   // age 1 = clear, 2..T+1 = taps 0..T-1, T+2 = done; the job ends after that.
   logic [N-1:0] m_pend, m_ovr;
   int m_rr, m_act, m_age, m_stage, m_sel;

   task automatic model_edge(input logic [N-1:0] r, input logic rst);
      int win;
      if (rst) begin
         m_pend = '0; m_ovr = '0; m_rr = 0; m_act = 0; m_age = 0;
         m_stage = 0; m_sel = 0;
      end else begin
         win = -1;
         if (m_act == 0)
            for (int k = 0; k < N; k++)
               if (win < 0 && m_pend[(m_rr + k) % N]) win = (m_rr + k) % N;
         for (int i = 0; i < N; i++) begin
            if (r[i] && m_pend[i] && win != i) m_ovr[i] = 1'b1;
            m_pend[i] = r[i] | (m_pend[i] && win != i);
         end
         if (m_act != 0) begin
            m_age++;
            if (m_age == T + 3) begin
               m_act = 0;
               m_rr  = (m_stage + 1) % N;
            end
         end else if (win >= 0) begin
            m_act = 1; m_age = 1; m_stage = win; m_sel = win;
         end
      end
   endtask

   function automatic logic [31:0] exp_vec();
      logic clr, en, last, dn, busy;
      logic [3:0] tap;
      logic [1:0] sel, ds;
      clr  = (m_act != 0) && m_age == 1;
      en   = (m_act != 0) && m_age >= 2 && m_age <= T + 1;
      tap  = en ? 4'(m_age - 2) : 4'd0;
      last = en && m_age == T + 1;
      dn   = (m_act != 0) && m_age == T + 2;
      ds   = dn ? 2'(m_stage) : 2'd0;
      busy = (m_act != 0);
      sel  = 2'(m_sel);
      return {15'd0, clr, en, last, tap, sel, dn, ds, busy, m_ovr};
   endfunction

   function automatic logic [31:0] act_vec();
      return {15'd0, mac_clear_out, mac_en_out, mac_last_out, tap_idx_out,
              stage_sel_out, done_out, done_stage_out, busy_out, overrun_out};
   endfunction

   task automatic step(input logic [N-1:0] r, input logic rst);
      req_in = r;
      rst_in = rst;
      @(posedge clk_in);
      model_edge(r, rst);
      #1;
      req_in = '0;
      rst_in = 1'b0;
   endtask

   task automatic test_reset();
      step('0, 1'b1);
      step('0, 1'b1);
      vectors++;
      if (act_vec() !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_state: got %h want %h", act_vec(), 32'h0);
      end
   endtask

   // req sampled at edge t; observations after k more edges show cycle t+1+k.
   task automatic test_single();
      int k_clr, k_en0, k_last, k_done;
      step('0, 1'b1);
      for (int i = 0; i < 9; i++) step('0, 1'b0);
      step(4'b0001, 1'b0);
      k_clr = -1; k_en0 = -1; k_last = -1; k_done = -1;
      for (int k = 1; k <= 24; k++) begin
         step('0, 1'b0);
         vectors++;
         if (act_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL single k=%0d: got %h want %h", k, act_vec(), exp_vec());
         end
         if (mac_clear_out && k_clr < 0) k_clr = k;
         if (mac_en_out && k_en0 < 0) k_en0 = k;
         if (mac_last_out && k_last < 0) k_last = k;
         if (done_out && k_done < 0) k_done = k;
      end
      vectors++;
      if ({k_clr, k_en0, k_last, k_done} !== {32'sd1, 32'sd2, 32'sd17, 32'sd18}) begin
         miscompares++;
         $display("FAIL single_latency: got clr/en/last/done %0d/%0d/%0d/%0d want 1/2/17/18",
                  k_clr, k_en0, k_last, k_done);
      end
   endtask

   task automatic test_all_four();
      int stg[$];
      int cyc[$];
      step('0, 1'b1);
      step(4'b1111, 1'b0);
      for (int k = 1; k <= 90; k++) begin
         step('0, 1'b0);
         vectors++;
         if (act_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL all_four k=%0d: got %h want %h", k, act_vec(), exp_vec());
         end
         if (done_out) begin stg.push_back(int'(done_stage_out)); cyc.push_back(k); end
      end
      vectors++;
      if (stg.size() != 4) begin
         miscompares++;
         $display("FAIL all_four_count: got %0d dones want 4", stg.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            vectors++;
            if (stg[i] != i || (i > 0 && cyc[i] - cyc[i-1] != 19)) begin
               miscompares++;
               $display("FAIL all_four_order[%0d]: got stage %0d gap %0d want stage %0d gap 19",
                        i, stg[i], i > 0 ? cyc[i] - cyc[i-1] : 19, i);
            end
         end
      end
      vectors++;
      if (overrun_out !== 4'b0000) begin
         miscompares++;
         $display("FAIL all_four_overrun: got %b want 0000", overrun_out);
      end
   endtask

   task automatic test_rr_wrap();
      int stg[$];
      int guard;
      step('0, 1'b1);
      step(4'b0100, 1'b0);
      guard = 0;
      while (!done_out && guard < 40) begin step('0, 1'b0); guard++; end
      vectors++;
      if (!done_out) begin
         miscompares++;
         $display("FAIL rr_wrap_first_done: got no done within 40 cycles want done");
      end
      step(4'b0101, 1'b0);
      for (int k = 1; k <= 50; k++) begin
         step('0, 1'b0);
         vectors++;
         if (act_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL rr_wrap k=%0d: got %h want %h", k, act_vec(), exp_vec());
         end
         if (done_out) stg.push_back(int'(done_stage_out));
      end
      vectors++;
      if (stg.size() != 2 || stg[0] != 0 || stg[1] != 2) begin
         miscompares++;
         $display("FAIL rr_wrap_order: got %p want '{0, 2}", stg);
      end
   endtask

   task automatic test_overrun();
      int n1;
      step('0, 1'b1);
      step(4'b0001, 1'b0);
      for (int i = 0; i < 3; i++) step('0, 1'b0);
      step(4'b0010, 1'b0);
      step('0, 1'b0);
      step('0, 1'b0);
      step(4'b0010, 1'b0);
      n1 = 0;
      for (int k = 1; k <= 60; k++) begin
         step('0, 1'b0);
         vectors++;
         if (act_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL overrun k=%0d: got %h want %h", k, act_vec(), exp_vec());
         end
         if (done_out && done_stage_out == 2'd1) n1++;
      end
      vectors++;
      if (overrun_out !== 4'b0010 || n1 != 1) begin
         miscompares++;
         $display("FAIL overrun_sticky: got ovr=%b stage1_dones=%0d want ovr=0010 dones=1",
                  overrun_out, n1);
      end
   endtask

   task automatic test_back_to_back();
      int cyc[$];
      step('0, 1'b1);
      step(4'b1000, 1'b0);
      step(4'b1000, 1'b0);   // lands on the grant edge for stage 3
      for (int k = 1; k <= 50; k++) begin
         step('0, 1'b0);
         vectors++;
         if (act_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL back_to_back k=%0d: got %h want %h", k, act_vec(), exp_vec());
         end
         if (done_out && done_stage_out == 2'd3) cyc.push_back(k);
      end
      vectors++;
      if (cyc.size() != 2 || cyc[1] - cyc[0] != 19 || overrun_out !== 4'b0000) begin
         miscompares++;
         $display("FAIL back_to_back_twice: got %0d dones ovr=%b want 2 dones 19 apart ovr=0000",
                  cyc.size(), overrun_out);
      end
   endtask

   task automatic test_reset_midjob();
      int guard, ndone;
      step('0, 1'b1);
      step(4'b0001, 1'b0);
      step(4'b0100, 1'b0);
      step(4'b0001, 1'b0);
      step(4'b0001, 1'b0);   // stage 0 already pending: raises an overrun
      guard = 0;
      while (!(mac_en_out && tap_idx_out == 4'd7) && guard < 30) begin
         step('0, 1'b0); guard++;
      end
      vectors++;
      if (!(mac_en_out && tap_idx_out == 4'd7)) begin
         miscompares++;
         $display("FAIL reset_mid_reach: got en=%b tap=%0d want en=1 tap=7", mac_en_out, tap_idx_out);
      end
      step('0, 1'b1);
      vectors++;
      if (act_vec() !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_mid_outputs: got %h want %h", act_vec(), 32'h0);
      end
      ndone = 0;
      for (int k = 1; k <= 40; k++) begin
         step('0, 1'b0);
         vectors++;
         if (act_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_mid k=%0d: got %h want %h", k, act_vec(), exp_vec());
         end
         if (done_out || busy_out) ndone++;
      end
      vectors++;
      if (ndone != 0) begin
         miscompares++;
         $display("FAIL reset_mid_no_job: got %0d busy/done cycles want 0", ndone);
      end
   endtask

   task automatic test_random();
      logic [N-1:0] r;
      logic rst;
      step('0, 1'b1);
      for (int k = 0; k < 2000; k++) begin
         for (int i = 0; i < N; i++) r[i] = ($urandom_range(0, 19) == 0);
         rst = ($urandom_range(0, 599) == 0);
         step(r, rst);
         vectors++;
         if (act_vec() !== exp_vec() || (mac_clear_out && mac_en_out)) begin
            miscompares++;
            $display("FAIL random k=%0d: got %h want %h", k, act_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      rst_in = 1'b1;
      req_in = '0;
      m_pend = '0; m_ovr = '0; m_rr = 0; m_act = 0; m_age = 0; m_stage = 0; m_sel = 0;
      #1;
      test_reset();
      test_single();
      test_all_four();
      test_rr_wrap();
      test_overrun();
      test_back_to_back();
      test_reset_midjob();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
